// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU operation codes
// and the control bundle latched into ID/EX (with its bubble value).
package mips_pkg;

   localparam int NB_ALU_OP = 3;

   localparam logic [5:0] OP_R_TYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_LBU    = 6'b100100;
   localparam logic [5:0] OP_LHU    = 6'b100101;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_SRL = 6'b000010;
   localparam logic [5:0] FUNCT_SRA = 6'b000011;

   localparam logic [NB_ALU_OP-1:0] ALU_R_TYPE = 3'b000;
   localparam logic [NB_ALU_OP-1:0] ALU_ADD    = 3'b001;
   localparam logic [NB_ALU_OP-1:0] ALU_AND    = 3'b010;
   localparam logic [NB_ALU_OP-1:0] ALU_OR     = 3'b011;
   localparam logic [NB_ALU_OP-1:0] ALU_XOR    = 3'b100;
   localparam logic [NB_ALU_OP-1:0] ALU_LUI    = 3'b101;
   localparam logic [NB_ALU_OP-1:0] ALU_SLT    = 3'b110;
   localparam logic [NB_ALU_OP-1:0] ALU_SUB    = 3'b111;

   typedef struct packed {
      logic                 shift_source;
      logic                 register_destination;
      logic                 alu_source;
      logic [NB_ALU_OP-1:0] alu_operation;
      logic                 mem_read;
      logic                 mem_write;
      logic                 mem_to_reg;
      logic                 reg_write;
      logic                 branch;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // Immediate-form ALU instruction: rt destination, immediate operand, writes back.
   function automatic ctrl_t ctrl_imm(input logic [NB_ALU_OP-1:0] op);
      ctrl_t c;
      c                      = CTRL_BUBBLE;
      c.register_destination = 1'b1;
      c.alu_source           = 1'b1;
      c.reg_write            = 1'b1;
      c.alu_operation        = op;
      return c;
   endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry register file, two combinational read ports, one write port, r0 = 0.
// DECODE_REG_BYPASS_EN: same-cycle write to a read address is forwarded to the read.
module register_file
#(
   parameter int NB_DATA        = 32,
   parameter int NB_REG_ADDRESS = 5
)
(
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic                      i_write_enable,
   input  logic [NB_REG_ADDRESS-1:0] i_write_address,
   input  logic [NB_DATA-1:0]        i_write_data,
   input  logic [NB_REG_ADDRESS-1:0] i_ra_address,
   input  logic [NB_REG_ADDRESS-1:0] i_rb_address,
   output logic [NB_DATA-1:0]        o_ra_data,
   output logic [NB_DATA-1:0]        o_rb_data
);

   localparam int NB_REGS = 2**NB_REG_ADDRESS;

   logic [NB_DATA-1:0] regs [NB_REGS];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NB_REGS; i++) regs[i] <= '0;
      end else if (i_write_enable && (i_write_address != '0)) begin
         regs[i_write_address] <= i_write_data;
      end
   end

   always_comb begin
      o_ra_data = '0;
      o_rb_data = '0;
      if (i_ra_address != '0) o_ra_data = regs[i_ra_address];
      if (i_rb_address != '0) o_rb_data = regs[i_rb_address];
`ifdef DECODE_REG_BYPASS_EN
      if (i_write_enable && (i_write_address != '0)) begin
         if (i_write_address == i_ra_address) o_ra_data = i_write_data;
         if (i_write_address == i_rb_address) o_rb_data = i_write_data;
      end
`endif
   end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: register read, control decode, immediate extension, ID/EX register.
// Same-cycle write-through in the register file is enabled by DECODE_REG_BYPASS_EN.
module instruction_decode
   import mips_pkg::*;
#(
   parameter int NB_DATA         = 32,
   parameter int NB_REG_ADDRESS  = 5,
   parameter int NB_OP_FIELD     = 6,
   parameter int NB_ALU_OP_FIELD = 3
)
(
   input  logic                       i_clock,
   input  logic                       i_reset_n,
   input  logic [NB_DATA-1:0]         i_instruction,
   input  logic                       i_valid,
   input  logic                       i_stall,
   input  logic                       i_flush,
   input  logic                       i_wb_write_enable,
   input  logic [NB_REG_ADDRESS-1:0]  i_wb_address,
   input  logic [NB_DATA-1:0]         i_wb_data,
   output logic [NB_DATA-1:0]         o_ra_data,
   output logic [NB_DATA-1:0]         o_rb_data,
   output logic [NB_DATA-1:0]         o_sign_extender_data,
   output logic [NB_REG_ADDRESS-1:0]  o_rs_address,
   output logic [NB_REG_ADDRESS-1:0]  o_rt_address,
   output logic [NB_REG_ADDRESS-1:0]  o_rd_address,
   output logic                       o_shift_source,
   output logic                       o_register_destination,
   output logic                       o_alu_source,
   output logic [NB_ALU_OP_FIELD-1:0] o_alu_operation,
   output logic                       o_mem_read,
   output logic                       o_mem_write,
   output logic                       o_mem_to_reg,
   output logic                       o_reg_write,
   output logic                       o_branch,
   output logic                       o_valid
);

   logic [NB_OP_FIELD-1:0]    opcode_p0;
   logic [NB_OP_FIELD-1:0]    funct_p0;
   logic [NB_REG_ADDRESS-1:0] rs_p0, rt_p0, rd_p0;
   logic [NB_DATA-1:0]        ra_p0, rb_p0, imm_p0;
   logic signed [NB_DATA-1:0] imm_sext_p0;
   ctrl_t                     ctrl_p0;
   logic                      bubble_p0, load_p0;

   logic [NB_DATA-1:0]        ra_p1, rb_p1, imm_p1;
   logic [NB_REG_ADDRESS-1:0] rs_p1, rt_p1, rd_p1;
   ctrl_t                     ctrl_p1;
   logic                      vld_p1;

   assign opcode_p0   = i_instruction[NB_DATA-1 -: NB_OP_FIELD];
   assign funct_p0    = i_instruction[NB_OP_FIELD-1:0];
   assign rs_p0       = i_instruction[21 +: NB_REG_ADDRESS];
   assign rt_p0       = i_instruction[16 +: NB_REG_ADDRESS];
   assign rd_p0       = i_instruction[11 +: NB_REG_ADDRESS];
   assign imm_sext_p0 = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};

   register_file #(
      .NB_DATA        (NB_DATA),
      .NB_REG_ADDRESS (NB_REG_ADDRESS)
   ) u_register_file (
      .i_clock         (i_clock),
      .i_reset_n       (i_reset_n),
      .i_write_enable  (i_wb_write_enable),
      .i_write_address (i_wb_address),
      .i_write_data    (i_wb_data),
      .i_ra_address    (rs_p0),
      .i_rb_address    (rt_p0),
      .o_ra_data       (ra_p0),
      .o_rb_data       (rb_p0)
   );

   always_comb begin
      ctrl_p0 = CTRL_BUBBLE;
      imm_p0  = imm_sext_p0;
      case (opcode_p0)
         OP_R_TYPE: begin
            ctrl_p0.reg_write     = 1'b1;
            ctrl_p0.alu_operation = ALU_R_TYPE;
            ctrl_p0.shift_source  = (funct_p0 == FUNCT_SLL) || (funct_p0 == FUNCT_SRL) ||
                                    (funct_p0 == FUNCT_SRA);
         end
         OP_ADDI, OP_ADDIU: ctrl_p0 = ctrl_imm(ALU_ADD);
         OP_SLTI:           ctrl_p0 = ctrl_imm(ALU_SLT);
         OP_ANDI: begin
            ctrl_p0 = ctrl_imm(ALU_AND);
            imm_p0  = {{(NB_DATA-16){1'b0}}, i_instruction[15:0]};
         end
         OP_ORI: begin
            ctrl_p0 = ctrl_imm(ALU_OR);
            imm_p0  = {{(NB_DATA-16){1'b0}}, i_instruction[15:0]};
         end
         OP_XORI: begin
            ctrl_p0 = ctrl_imm(ALU_XOR);
            imm_p0  = {{(NB_DATA-16){1'b0}}, i_instruction[15:0]};
         end
         OP_LUI: begin
            ctrl_p0 = ctrl_imm(ALU_LUI);
            imm_p0  = {i_instruction[15:0], {(NB_DATA-16){1'b0}}};
         end
         OP_LW, OP_LH, OP_LB, OP_LHU, OP_LBU: begin
            ctrl_p0            = ctrl_imm(ALU_ADD);
            ctrl_p0.mem_read   = 1'b1;
            ctrl_p0.mem_to_reg = 1'b1;
         end
         OP_SW, OP_SH, OP_SB: begin
            ctrl_p0.alu_operation = ALU_ADD;
            ctrl_p0.alu_source    = 1'b1;
            ctrl_p0.mem_write     = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            ctrl_p0.alu_operation = ALU_SUB;
            ctrl_p0.branch        = 1'b1;
         end
         default: ;
      endcase
   end

   // ID/EX boundary: flush beats stall; an unstalled non-valid slot becomes a bubble.
   assign bubble_p0 = i_flush | ~i_valid;
   assign load_p0   = i_flush | ~i_stall;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ra_p1   <= '0;
         rb_p1   <= '0;
         imm_p1  <= '0;
         rs_p1   <= '0;
         rt_p1   <= '0;
         rd_p1   <= '0;
         ctrl_p1 <= CTRL_BUBBLE;
         vld_p1  <= 1'b0;
      end else if (load_p0) begin
         ra_p1   <= bubble_p0 ? '0 : ra_p0;
         rb_p1   <= bubble_p0 ? '0 : rb_p0;
         imm_p1  <= bubble_p0 ? '0 : imm_p0;
         rs_p1   <= bubble_p0 ? '0 : rs_p0;
         rt_p1   <= bubble_p0 ? '0 : rt_p0;
         rd_p1   <= bubble_p0 ? '0 : rd_p0;
         ctrl_p1 <= bubble_p0 ? CTRL_BUBBLE : ctrl_p0;
         vld_p1  <= ~bubble_p0;
      end
   end

   assign o_ra_data              = ra_p1;
   assign o_rb_data              = rb_p1;
   assign o_sign_extender_data   = imm_p1;
   assign o_rs_address           = rs_p1;
   assign o_rt_address           = rt_p1;
   assign o_rd_address           = rd_p1;
   assign o_shift_source         = ctrl_p1.shift_source;
   assign o_register_destination = ctrl_p1.register_destination;
   assign o_alu_source           = ctrl_p1.alu_source;
   assign o_alu_operation        = ctrl_p1.alu_operation;
   assign o_mem_read             = ctrl_p1.mem_read;
   assign o_mem_write            = ctrl_p1.mem_write;
   assign o_mem_to_reg           = ctrl_p1.mem_to_reg;
   assign o_reg_write            = ctrl_p1.reg_write;
   assign o_branch               = ctrl_p1.branch;
   assign o_valid                = vld_p1;

endmodule
